if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction fetch stage of the pipelined RV32I core: owns the PC and issues one-outstanding requests to instruction memory.
//  Fills the IF/ID register and presents split fields (opcode/funct7/funct3) to the control decoder, which is the consumer.
//  Takes the decoder's NPCOp back from EX as a redirect and flushes wrong-path fetches.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC fetched first after reset
//  NOP_INSTR 32'h0000_0013  value in id_instr when the slot is empty (addi x0,x0,0)
// PORTS
//  clk          in   1   core clock, all state on rising edge
//  rstn         in   1   synchronous active-low reset
//  imem_req     out  1   fetch request, accepted the same cycle it is high
//  imem_addr    out  32  word-aligned fetch address
//  imem_rvalid  in   1   response valid, >=1 cycle after request
//  imem_rdata   in   32  instruction word, qualified by imem_rvalid
//  id_stall     in   1   hazard unit: hold IF/ID contents
//  ex_valid     in   1   EX stage holds a real instruction
//  ex_npc_op    in   3   NPCOp from EX: 000 +4, 001 branch, 010 jal, 100 jalr
//  ex_br_taken  in   1   branch condition result from EX
//  ex_pc        in   32  PC of EX instruction
//  ex_imm       in   32  extended immediate of EX instruction
//  ex_alu_out   in   32  ALU result (rs1+imm for jalr)
//  id_valid     out  1   IF/ID holds a valid instruction
//  id_instr     out  32  instruction word
//  id_pc        out  32  its PC
//  id_pc4       out  32  its PC+4 (link value for WDSel=PC)
//  id_op        out  7   id_instr[6:0]
//  id_funct3    out  3   id_instr[14:12]
//  id_funct7    out  7   id_instr[31:25]
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=FETCH, drop=0, id_valid=0, id_instr=NOP_INSTR, id_pc=id_pc4=0; imem_req=0 while rstn=0.
//  Redirect (redir) = ex_valid & (npc_op==010 | npc_op==100 | (npc_op==001 & ex_br_taken)).
//  Target: branch/jal = ex_pc+ex_imm (mod 2^32); jalr = ex_alu_out & ~1; bits[1:0] forced to 00 on imem_addr.
//  States: FETCH, WAIT, HOLD. Registers pc, pc_req, hold_instr, drop.
//  FETCH: imem_req=1, imem_addr=pc, next WAIT, pc_req<=pc. With redir this cycle: imem_req=0, pc<=target, stay FETCH.
//  WAIT: imem_req=0. redir w/o rvalid: pc<=target, drop<=1. rvalid & (drop|redir): discard, drop<=0, ->FETCH (pc<=target on redir).
//   Otherwise, on rvalid with IF/ID free (~id_valid | ~id_stall): load IF/ID, pc<=pc_req+4, ->FETCH.
//   Otherwise, on rvalid with IF/ID full: hold_instr<=rdata, pc<=pc_req+4, ->HOLD.
//  HOLD: on ~id_stall, load IF/ID from hold_instr/pc_req, ->FETCH. redir: discard buffer, pc<=target, ->FETCH.
//  IF/ID update priority: redir > id_stall > load > bubble.
//   redir: id_valid<=0, id_instr<=NOP_INSTR (overrides stall).
//   id_stall: hold all fields.
//   load: id_valid<=1, id_instr, id_pc=pc_req, id_pc4=pc_req+4.
//   else: id_valid<=0, id_instr<=NOP_INSTR.
//  Field outputs are combinational slices of registered id_instr; no other comb path from inputs to id_* outputs.
//  At most one outstanding request; never assert imem_req outside FETCH. Reset mid-WAIT: late rvalid after reset is ignored
//   (first post-reset cycle is FETCH and rvalid is only sampled in WAIT).
//  Latency: no stall, 1-cycle memory: one instruction every 2 cycles; redirect-to-new-request 1 cycle.
// TESTING
//  Reset, 1-cycle imem returning addr-as-data: req addrs 0,4,8; id_pc 0,4,8; id_valid high every 2nd cycle.
//  id_stall high 3 cycles with response arriving: HOLD entered; instr at 0x8 appears in IF/ID once after stall drops; none lost or duplicated.
//  jal redirect (ex_pc=0x10, ex_imm=0x20) while in WAIT: response discarded; next req addr 0x30; id_valid=0 in the cycle after redirect.
//  jalr ex_alu_out=0x45 concurrent with rvalid: response discarded; next imem_addr=0x44.
//  Branch npc_op=001 with ex_br_taken=0: no flush, sequential fetch continues; ex_br_taken=1, imm=-8 at pc 0x20 -> next fetch 0x18.
//  rstn low during WAIT, then rvalid pulses after release: id_valid stays 0; first req addr RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// RV32I instruction fetch stage: PC ownership, single-outstanding imem
// requests, IF/ID register and EX-driven redirect/flush.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        ex_valid,
  input  logic [2:0]  ex_npc_op,
  input  logic        ex_br_taken,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_alu_out,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [6:0]  id_op,
  output logic [2:0]  id_funct3,
  output logic [6:0]  id_funct7
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] pc_req, pc_req_n;
  logic [31:0] hold_instr, hold_n;
  logic        drop, drop_n;

  logic        op_br, op_jal, op_jalr;
  logic        redir;
  logic [31:0] target;
  logic [31:0] seq_pc;

  logic        load;
  logic [31:0] load_instr;

  assign op_br   = ex_npc_op == 3'b001;
  assign op_jal  = ex_npc_op == 3'b010;
  assign op_jalr = ex_npc_op == 3'b100;
  assign redir   = ex_valid &
                   (op_jal | op_jalr | (op_br & ex_br_taken));

  always_comb begin
    target = ex_pc + ex_imm;
    unique case (1'b1)
      op_jalr: target = ex_alu_out & ~32'h1;
      default: target = ex_pc + ex_imm;
    endcase
    target = target & ~32'h3;
  end

  assign seq_pc    = pc_req + 32'd4;
  assign imem_addr = {pc[31:2], 2'b00};

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    pc_req_n   = pc_req;
    hold_n     = hold_instr;
    drop_n     = drop;
    load       = 1'b0;
    load_instr = imem_rdata;
    imem_req   = 1'b0;
    unique case (state)
      FETCH: begin
        if (redir) begin
          pc_n = target;
        end else begin
          imem_req = rstn;
          pc_req_n = pc;
          state_n  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (drop | redir) begin
            drop_n  = 1'b0;
            state_n = FETCH;
            if (redir) pc_n = target;
          end else if (~id_valid | ~id_stall) begin
            load    = 1'b1;
            pc_n    = seq_pc;
            state_n = FETCH;
          end else begin
            hold_n  = imem_rdata;
            pc_n    = seq_pc;
            state_n = HOLD;
          end
        end else if (redir) begin
          pc_n   = target;
          drop_n = 1'b1;
        end
      end
      HOLD: begin
        if (redir) begin
          pc_n    = target;
          state_n = FETCH;
        end else if (~id_stall) begin
          load       = 1'b1;
          load_instr = hold_instr;
          state_n    = FETCH;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      pc_req     <= RESET_PC;
      hold_instr <= NOP_INSTR;
      drop       <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      pc_req     <= pc_req_n;
      hold_instr <= hold_n;
      drop       <= drop_n;
    end
  end

  // A load into a stalled slot only happens when that slot is empty.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
      id_pc    <= 32'h0;
      id_pc4   <= 32'h0;
    end else if (redir) begin
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
    end else if (load) begin
      id_valid <= 1'b1;
      id_instr <= load_instr;
      id_pc    <= pc_req;
      id_pc4   <= seq_pc;
    end else if (!id_stall) begin
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
    end
  end

  assign id_op     = id_instr[6:0];
  assign id_funct3 = id_instr[14:12];
  assign id_funct7 = id_instr[31:25];

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed cycle-by-cycle bench for if_fetch_unit.
// Inputs change 1ns after the rising edge; outputs sampled 1ns later.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        ex_valid;
  logic [2:0]  ex_npc_op;
  logic        ex_br_taken;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_alu_out;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic [6:0]  id_op;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk(clk),
    .rstn(rstn),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .id_stall(id_stall),
    .ex_valid(ex_valid),
    .ex_npc_op(ex_npc_op),
    .ex_br_taken(ex_br_taken),
    .ex_pc(ex_pc),
    .ex_imm(ex_imm),
    .ex_alu_out(ex_alu_out),
    .id_valid(id_valid),
    .id_instr(id_instr),
    .id_pc(id_pc),
    .id_pc4(id_pc4),
    .id_op(id_op),
    .id_funct3(id_funct3),
    .id_funct7(id_funct7)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rv, input logic [31:0] rd,
                       input logic st, input logic exv,
                       input logic [2:0] op, input logic bt,
                       input logic [31:0] epc, input logic [31:0] imm,
                       input logic [31:0] alu);
    imem_rvalid = rv;
    imem_rdata  = rd;
    id_stall    = st;
    ex_valid    = exv;
    ex_npc_op   = op;
    ex_br_taken = bt;
    ex_pc       = epc;
    ex_imm      = imm;
    ex_alu_out  = alu;
    #1;
  endtask

  task automatic idle(input logic rv, input logic [31:0] rd,
                      input logic st);
    drive(rv, rd, st, 1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    rstn = 1'b0;
    idle(1'b0, 32'h0, 1'b0);
    tick();
    tick();
    idle(1'b0, 32'h0, 1'b0);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_valid", {31'h0, id_valid}, 32'h0);
    chk("rst_instr", id_instr, 32'h0000_0013);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_pc4", id_pc4, 32'h0);

    // sequential fetch, 1-cycle memory echoing the address
    rstn = 1'b1;
    idle(1'b0, 32'h0, 1'b0);
    chk("f0_req", {31'h0, imem_req}, 32'h1);
    chk("f0_addr", imem_addr, 32'h0);
    tick();
    idle(1'b1, 32'h0, 1'b0);
    chk("w0_req", {31'h0, imem_req}, 32'h0);
    chk("w0_valid", {31'h0, id_valid}, 32'h0);
    tick();
    idle(1'b0, 32'h0, 1'b0);
    chk("f1_addr", imem_addr, 32'h4);
    chk("f1_valid", {31'h0, id_valid}, 32'h1);
    chk("f1_pc", id_pc, 32'h0);
    chk("f1_pc4", id_pc4, 32'h4);
    tick();
    idle(1'b1, 32'h4, 1'b0);
    chk("w1_valid", {31'h0, id_valid}, 32'h0);
    tick();

    // stall for 3 cycles while the response for 0x8 arrives
    idle(1'b0, 32'h0, 1'b1);
    chk("f2_addr", imem_addr, 32'h8);
    chk("f2_valid", {31'h0, id_valid}, 32'h1);
    chk("f2_pc", id_pc, 32'h4);
    chk("f2_instr", id_instr, 32'h4);
    tick();
    idle(1'b1, 32'h8, 1'b1);
    chk("w2_pc_held", id_pc, 32'h4);
    tick();
    idle(1'b0, 32'h0, 1'b1);
    chk("h0_req", {31'h0, imem_req}, 32'h0);
    chk("h0_pc_held", id_pc, 32'h4);
    chk("h0_valid", {31'h0, id_valid}, 32'h1);
    tick();
    idle(1'b0, 32'h0, 1'b0);
    chk("h1_req", {31'h0, imem_req}, 32'h0);
    tick();
    idle(1'b0, 32'h0, 1'b0);
    chk("f3_addr", imem_addr, 32'hC);
    chk("f3_valid", {31'h0, id_valid}, 32'h1);
    chk("f3_pc", id_pc, 32'h8);
    chk("f3_instr", id_instr, 32'h8);
    tick();

    // jal redirect in WAIT before the response
    drive(1'b0, 32'h0, 1'b0, 1'b1, 3'b010, 1'b0,
          32'h10, 32'h20, 32'h0);
    chk("jal_req", {31'h0, imem_req}, 32'h0);
    chk("jal_nodup", {31'h0, id_valid}, 32'h0);
    tick();
    idle(1'b1, 32'hC, 1'b0);
    chk("jal_flush", {31'h0, id_valid}, 32'h0);
    chk("jal_instr", id_instr, 32'h0000_0013);
    tick();
    idle(1'b0, 32'h0, 1'b0);
    chk("jal_drop", {31'h0, id_valid}, 32'h0);
    chk("jal_req2", {31'h0, imem_req}, 32'h1);
    chk("jal_addr", imem_addr, 32'h30);
    tick();

    // jalr together with rvalid
    drive(1'b1, 32'h30, 1'b0, 1'b1, 3'b100, 1'b0,
          32'h0, 32'h0, 32'h45);
    tick();
    idle(1'b0, 32'h0, 1'b0);
    chk("jalr_valid", {31'h0, id_valid}, 32'h0);
    chk("jalr_req", {31'h0, imem_req}, 32'h1);
    chk("jalr_addr", imem_addr, 32'h44);
    tick();

    // branch not taken alongside the response
    drive(1'b1, 32'h44, 1'b0, 1'b1, 3'b001, 1'b0,
          32'h20, 32'hFFFF_FFF8, 32'h0);
    tick();
    // branch taken while in FETCH
    drive(1'b0, 32'h0, 1'b0, 1'b1, 3'b001, 1'b1,
          32'h20, 32'hFFFF_FFF8, 32'h0);
    chk("bnt_valid", {31'h0, id_valid}, 32'h1);
    chk("bnt_pc", id_pc, 32'h44);
    chk("bnt_pc4", id_pc4, 32'h48);
    chk("bnt_instr", id_instr, 32'h44);
    chk("bt_req", {31'h0, imem_req}, 32'h0);
    tick();
    idle(1'b0, 32'h0, 1'b0);
    chk("bt_valid", {31'h0, id_valid}, 32'h0);
    chk("bt_req2", {31'h0, imem_req}, 32'h1);
    chk("bt_addr", imem_addr, 32'h18);
    tick();

    // reset in WAIT, stale rvalid after release
    rstn = 1'b0;
    idle(1'b0, 32'h0, 1'b0);
    tick();
    chk("mrst_req", {31'h0, imem_req}, 32'h0);
    rstn = 1'b1;
    idle(1'b1, 32'h18, 1'b0);
    chk("mrst_valid", {31'h0, id_valid}, 32'h0);
    chk("mrst_req2", {31'h0, imem_req}, 32'h1);
    chk("mrst_addr", imem_addr, 32'h0);
    tick();
    idle(1'b0, 32'h0, 1'b0);
    chk("mrst_stale", {31'h0, id_valid}, 32'h0);
    tick();
    chk("mrst_wait", {31'h0, id_valid}, 32'h0);
    idle(1'b1, 32'h40B5_7533, 1'b0);
    tick();
    idle(1'b0, 32'h0, 1'b0);
    chk("fld_valid", {31'h0, id_valid}, 32'h1);
    chk("fld_pc", id_pc, 32'h0);
    chk("fld_op", {25'h0, id_op}, 32'h33);
    chk("fld_f3", {29'h0, id_funct3}, 32'h7);
    chk("fld_f7", {25'h0, id_funct7}, 32'h20);
    chk("fld_addr", imem_addr, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
